// File: rtl/nn_argmax_classifier_if.sv
// Stream-in / result-out handshake bundle for the argmax classifier.
// The classifier sits on the slave side; the score source and result consumer sit on the master side.
interface nn_argmax_classifier_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [IDX_W-1:0]  result_class;
  logic [DATA_W-1:0] result_score;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output s_axis_tdata, s_axis_tvalid, result_ready,
    input  s_axis_tready, result_class, result_score, result_valid
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, result_ready,
    output s_axis_tready, result_class, result_score, result_valid
  );
endinterface

// File: rtl/nn_argmax_classifier.sv
// Collects one frame of NUM_CLASSES scores and reports the index and value of the largest one.
// Ties keep the lower index; the result is held until consumed, and the stream is stalled meanwhile.
module nn_argmax_classifier #(
  parameter int DATA_W      = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4,
  parameter int SIGNED_CMP  = 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  abort,
  nn_argmax_classifier_if.slave axis,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  typedef enum logic {COLLECT, HOLD} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  best_idx;
  logic [DATA_W-1:0] best_score;
  logic [IDX_W-1:0]  class_q;
  logic [DATA_W-1:0] score_q;
  logic              tready_q;
  logic              valid_q;
  logic              busy_q;

  logic              beat_ok;
  logic              is_greater;
  logic              take_new;
  logic [IDX_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_score;

  assign beat_ok = axis.s_axis_tvalid & tready_q;

  // Winner after folding the current beat in; the first beat of a frame always seeds it.
  always_comb begin
    is_greater = 1'b0;
    if (SIGNED_CMP != 0)
      is_greater = $signed(axis.s_axis_tdata) > $signed(best_score);
    else
      is_greater = axis.s_axis_tdata > best_score;
    take_new  = (cnt == '0) || is_greater;
    win_score = take_new ? axis.s_axis_tdata : best_score;
    win_idx   = take_new ? cnt : best_idx;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= COLLECT;
      cnt         <= '0;
      best_idx    <= '0;
      best_score  <= '0;
      class_q     <= '0;
      score_q     <= '0;
      tready_q    <= 1'b1;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (abort) begin
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (beat_ok) begin
            best_score <= win_score;
            best_idx   <= win_idx;
            if (cnt == LAST_IDX) begin
              cnt      <= '0;
              state    <= HOLD;
              class_q  <= win_idx;
              score_q  <= win_score;
              tready_q <= 1'b0;
              valid_q  <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              cnt    <= cnt + IDX_W'(1);
              busy_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Abort wins over a simultaneous consume, so the frame is not counted.
          if (abort) begin
            state    <= COLLECT;
            valid_q  <= 1'b0;
            tready_q <= 1'b1;
          end else if (axis.result_ready) begin
            state       <= COLLECT;
            valid_q     <= 1'b0;
            tready_q    <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
        end
        default: begin
          state    <= COLLECT;
          tready_q <= 1'b1;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign axis.s_axis_tready = tready_q;
  assign axis.result_valid  = valid_q;
  assign axis.result_class  = class_q;
  assign axis.result_score  = score_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_nn_argmax_classifier.sv
// Scoreboard bench: a signed and an unsigned classifier see the same stream and are checked against a model.
// Expected winners are queued as frames are driven and popped when each result is consumed.
module tb_nn_argmax_classifier;

  logic        ACLK;
  logic        ARESET;
  logic        abort;
  logic        busy;
  logic [15:0] frame_count;
  logic        busy_u;
  logic [15:0] frame_count_u;

  typedef struct packed {
    logic [3:0]  cs;
    logic [31:0] ss;
    logic [3:0]  cu;
    logic [31:0] su;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] frame [10];
  int          totalChecks = 0;
  int          badChecks   = 0;

  nn_argmax_classifier_if #(.DATA_W(32), .IDX_W(4)) bus ();
  nn_argmax_classifier_if #(.DATA_W(32), .IDX_W(4)) bus_u ();

  assign bus_u.s_axis_tdata  = bus.s_axis_tdata;
  assign bus_u.s_axis_tvalid = bus.s_axis_tvalid;
  assign bus_u.result_ready  = bus.result_ready;

  nn_argmax_classifier #(.DATA_W(32), .NUM_CLASSES(10), .IDX_W(4), .SIGNED_CMP(1)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .abort(abort), .axis(bus),
    .busy(busy), .frame_count(frame_count)
  );

  nn_argmax_classifier #(.DATA_W(32), .NUM_CLASSES(10), .IDX_W(4), .SIGNED_CMP(0)) dut_u (
    .ACLK(ACLK), .ARESET(ARESET), .abort(abort), .axis(bus_u),
    .busy(busy_u), .frame_count(frame_count_u)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sendBeat(input logic [31:0] d);
    int n = 0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    while (!bus.s_axis_tready && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (n >= 200) checkOutput("beatTimeout", 32'd0, 32'd1);
    @(posedge ACLK); #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  // Drives the frame[] table; optionally queues the winner predicted for both signedness modes.
  task automatic applyStimulus(input bit gaps, input bit push);
    exp_t e;
    e.ss = frame[0]; e.cs = 4'd0;
    e.su = frame[0]; e.cu = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if ($signed(frame[i]) > $signed(e.ss)) begin e.ss = frame[i]; e.cs = 4'(i); end
      if (frame[i] > e.su) begin e.su = frame[i]; e.cu = 4'(i); end
    end
    if (push) expQ.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
      sendBeat(frame[i]);
    end
  endtask

  task automatic waitHandshake();
    int n = 0;
    while (!(bus.result_valid && bus.result_ready) && n < 100) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (n >= 100) checkOutput("handshakeTimeout", 32'd0, 32'd1);
    @(posedge ACLK); #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_tready"}, 32'(bus.s_axis_tready), 32'd1);
    checkOutput({tag, "_valid"},  32'(bus.result_valid),  32'd0);
    checkOutput({tag, "_class"},  32'(bus.result_class),  32'd0);
    checkOutput({tag, "_score"},  bus.result_score,       32'd0);
    checkOutput({tag, "_busy"},   32'(busy),              32'd0);
    checkOutput({tag, "_fcount"}, 32'(frame_count),       32'd0);
  endtask

  // Consumed results are compared at the falling edge before the handshake edge.
  always @(negedge ACLK) begin
    if (!ARESET && !abort && bus.result_valid && bus.result_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResult", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("classSigned",   32'(bus.result_class),   32'(e.cs));
        checkOutput("scoreSigned",   bus.result_score,        e.ss);
        checkOutput("validUnsigned", 32'(bus_u.result_valid), 32'd1);
        checkOutput("classUnsigned", 32'(bus_u.result_class), 32'(e.cu));
        checkOutput("scoreUnsigned", bus_u.result_score,      e.su);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] fcBefore;
    ARESET = 1'b1;
    abort  = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.result_ready  = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    checkResetState("reset");
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Ascending frame, consumer always ready: latency and single-cycle stall.
    bus.result_ready = 1'b1;
    for (int i = 0; i < 10; i++) frame[i] = 32'(i);
    applyStimulus(1'b0, 1'b1);
    checkOutput("latencyValid",   32'(bus.result_valid),   32'd1);
    checkOutput("stallTready",    32'(bus.s_axis_tready),  32'd0);
    checkOutput("stallTreadyU",   32'(bus_u.s_axis_tready), 32'd0);
    @(posedge ACLK); #1;
    checkOutput("releaseTready",  32'(bus.s_axis_tready),  32'd1);
    checkOutput("releaseValid",   32'(bus.result_valid),   32'd0);
    checkOutput("fcountFirst",    32'(frame_count),        32'd1);

    // Signedness cases.
    for (int i = 0; i < 10; i++) frame[i] = -32'sd5;
    frame[3] = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) frame[i] = 32'd1;
    frame[7] = 32'h8000_0000;
    applyStimulus(1'b0, 1'b1);

    // Ties keep the lower index.
    for (int i = 0; i < 10; i++) frame[i] = 32'd0;
    frame[2] = 32'd100;
    frame[6] = 32'd100;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) frame[i] = 32'd42;
    applyStimulus(1'b0, 1'b1);
    waitHandshake();

    // Bubbles inside the frame and a consumer that stalls for 20 cycles.
    bus.result_ready = 1'b0;
    for (int i = 0; i < 10; i++) frame[i] = $urandom_range(0, 5000);
    applyStimulus(1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      checkOutput("holdValid",  32'(bus.result_valid),  32'd1);
      checkOutput("holdTready", 32'(bus.s_axis_tready), 32'd0);
      if (expQ.size() != 0) begin
        checkOutput("holdClass", 32'(bus.result_class), 32'(expQ[0].cs));
        checkOutput("holdScore", bus.result_score,      expQ[0].ss);
      end
      @(posedge ACLK); #1;
    end
    bus.result_ready = 1'b1;
    waitHandshake();
    for (int i = 0; i < 10; i++) frame[i] = 32'(i);
    frame[5] = 32'd99999;
    applyStimulus(1'b1, 1'b1);
    waitHandshake();

    // Abort after three beats with a fourth beat in the abort edge.
    fcBefore = frame_count;
    for (int i = 0; i < 3; i++) sendBeat(32'd7777);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = 32'd8888;
    abort = 1'b1;
    @(posedge ACLK); #1;
    abort = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    checkOutput("abortBusy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) frame[i] = 32'(3 * i);
    frame[8] = 32'd1000;
    applyStimulus(1'b0, 1'b1);
    waitHandshake();
    checkOutput("abortFcount", 32'(frame_count), 32'(fcBefore + 16'd1));

    // Abort while holding a result.
    bus.result_ready = 1'b0;
    fcBefore = frame_count;
    applyStimulus(1'b0, 1'b0);
    checkOutput("preAbortValid", 32'(bus.result_valid), 32'd1);
    abort = 1'b1;
    @(posedge ACLK); #1;
    abort = 1'b0;
    checkOutput("holdAbortValid",  32'(bus.result_valid),  32'd0);
    checkOutput("holdAbortTready", 32'(bus.s_axis_tready), 32'd1);
    checkOutput("holdAbortFcount", 32'(frame_count),       32'(fcBefore));

    // Reset mid-frame and during hold.
    for (int i = 0; i < 6; i++) sendBeat(32'(100 + i));
    checkOutput("midFrameBusy", 32'(busy), 32'd1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checkResetState("midReset");
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    applyStimulus(1'b0, 1'b0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checkResetState("holdReset");
    ARESET = 1'b0;
    bus.result_ready = 1'b1;
    for (int i = 0; i < 10; i++) frame[i] = 32'(50 - i);
    frame[4] = 32'd77;
    applyStimulus(1'b1, 1'b1);
    waitHandshake();
    checkOutput("postResetFcount",  32'(frame_count),   32'd1);
    checkOutput("postResetFcountU", 32'(frame_count_u), 32'd1);

    repeat (2) @(posedge ACLK);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/nn_argmax_classifier.md
Name: nn_argmax_classifier

Overview:
- Downstream consumer of the PL_NN output activation stream (a_0_tdata/a_0_tvalid/a_0_tready).
- Takes one frame of NUM_CLASSES output-neuron scores, one beat per class, in index order 0..NUM_CLASSES-1.
- Picks the highest score and presents the winning class index plus its score on a valid/ready result port.
- A small status path gives the frame count and busy flag.

Parameters:
- DATA_W, 32, width of one score beat.
- NUM_CLASSES, 10, beats per frame (MNIST digits); legal range 2..16.
- IDX_W, 4, width of class index; must satisfy 2**IDX_W >= NUM_CLASSES.
- SIGNED_CMP, 1, 1 = compare scores as two's-complement signed, 0 = unsigned.

Ports:
- ACLK  input  1  clock; all logic on rising edge.
- ARESET  input  1  reset, synchronous, active-high.
- abort  input  1  synchronous frame discard.
- s_axis_tdata  input  DATA_W  score beat.
- s_axis_tvalid  input  1  beat valid.
- s_axis_tready  output  1  beat accept.
- result_class  output  IDX_W  winning class index.
- result_score  output  DATA_W  winning score.
- result_valid  output  1  result available.
- result_ready  input  1  result consumed.
- busy  output  1  high while a frame is partially received (beat count != 0).
- frame_count  output  16  completed frames delivered; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (ARESET high at a clock edge):
  - State goes to COLLECT, beat count cnt = 0.
  - Outputs: s_axis_tready = 1, result_valid = 0, result_class = 0, result_score = 0, busy = 0, frame_count = 0.
  - ARESET has priority over abort and over every handshake.
- States:
  - COLLECT: s_axis_tready = 1.
  - HOLD: s_axis_tready = 0, result_valid = 1.
- A beat is accepted when s_axis_tvalid & s_axis_tready are both high at a rising edge.
- COLLECT, accepted beat with cnt == 0: best_score <= tdata, best_idx <= 0.
- COLLECT, accepted beat with cnt > 0:
  - If tdata > best_score (strict, signedness per SIGNED_CMP): best_score <= tdata, best_idx <= cnt.
  - On ties the lower index is kept.
- Every accepted beat increments cnt.
- On the beat with cnt == NUM_CLASSES-1:
  - The comparison for that beat is applied in the same edge.
  - cnt <= 0, state <= HOLD.
  - result_class/result_score <= final winner.
  - result_valid rises on the next cycle. Latency is 1 cycle from the last beat's handshake edge to result_valid high.
- HOLD:
  - result_class and result_score stay stable.
  - result_valid stays high until result_valid & result_ready at an edge.
  - On that handshake: state <= COLLECT, frame_count <= frame_count + 1.
  - s_axis_tready returns high in the cycle after the handshake. There is no combinational path from result_ready to s_axis_tready.
  - Stream beats offered during HOLD are not accepted and stay pending on the source.
- result_ready high while result_valid is low has no effect.
- s_axis_tvalid gaps (bubbles) mid-frame: cnt and the best-so-far registers are held; the frame resumes with the next beat.
- abort high at an edge, no reset:
  - In COLLECT: cnt <= 0, partial frame discarded. Any beat handshaked in that same edge is discarded as well.
  - In HOLD: result_valid <= 0, state <= COLLECT, frame_count unchanged.
  - result_class/result_score keep their last values, but consumers must ignore them while result_valid is low.
- busy = (state == COLLECT && cnt != 0).
- frame_count wraps 0xFFFF -> 0x0000 silently.
- Internal cnt width is IDX_W; no arithmetic is wider than DATA_W. The compare is a single DATA_W-bit magnitude compare; no overflow cases exist.

Test Plan:
- Reset then frame 0,1,...,9 back-to-back, result_ready=1 -> result_valid 1 cycle after the 10th handshake; class 9, score 9; frame_count 1; s_axis_tready low exactly 1 cycle.
- SIGNED_CMP=1, frame where all beats = -5 except beat 3 = 32'hFFFF_FFFF (-1) -> class 3, score 32'hFFFF_FFFF. Repeat with SIGNED_CMP=0 and beat 7 = 32'h8000_0000, others 1 -> class 7.
- Ties: beats 2 and 6 both 100, others 0 -> class 2. Then a frame of all-equal 42 -> class 0, score 42.
- Backpressure and bubbles: random tvalid gaps inside a frame, result_ready held low 20 cycles -> result stable and valid for all 20 cycles, s_axis_tready 0 throughout, no beats lost. The next frame's winner at beat 5 -> class 5.
- abort after 4 beats, then a full new frame with max at beat 8 -> class 8, frame_count +1 only. abort during HOLD -> result_valid drops next cycle and frame_count unchanged.
- ARESET asserted mid-frame (cnt=6) and during HOLD -> next edge all outputs at reset values, frame_count 0. The following clean frame is classified correctly.
